aram_fifo_ctl_64x56: RTL and testbench

ARAM_FIFO_CTL_64X56 -- requirements
Module: aram_fifo_ctl_64x56

---
 rtl/aram_fifo_ctl_64x56.sv | 132 +++++++++++++
 tb/tb_aram_fifo_ctl_64x56.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aram_fifo_ctl_64x56.sv
// aram_fifo_ctl_64x56: 64 x 56-bit FIFO controller built around an external
// synchronous dual-port RAM (1-cycle read latency), plus a 2-entry output skid
// buffer so the consumer sees a registered head word.
//
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   wr_valid/wr_ready/     producer handshake and write word
//   wr_data
//   rd_valid/rd_ready/     consumer handshake and head-of-FIFO word
//   rd_data
//   ram_ena/ram_wea/       RAM write port
//   ram_addra/ram_dia
//   ram_enb/ram_addrb/     RAM read port; ram_dob returns the cycle after ram_enb
//   ram_dob
//   count                  total occupancy (RAM + in-flight read + output stage), 0..66
//   almost_full            count >= AFULL_THRESH
//
// Build option: define ARAM_FIFO_BYPASS_EN to let a push into a drained FIFO
// skip the RAM and load the output buffer directly (1-cycle latency instead of 3).
module aram_fifo_ctl_64x56 #(
  parameter int unsigned AFULL_THRESH = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [55:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [55:0] rd_data,
  output logic        ram_ena,
  output logic        ram_wea,
  output logic [5:0]  ram_addra,
  output logic [55:0] ram_dia,
  output logic        ram_enb,
  output logic [5:0]  ram_addrb,
  input  logic [55:0] ram_dob,
  output logic [6:0]  count,
  output logic        almost_full
);

  logic [5:0]  wptr_q, rptr_q;
  logic [6:0]  ram_cnt_q, ram_cnt_d;
  logic        inflight_q;
  logic [1:0]  out_cnt_q, out_cnt_d;
  logic [55:0] buf0_q, buf0_d, buf1_q, buf1_d;

  logic        push, pop, read_issue, bypass, ram_wr, load;
  logic [1:0]  occ_after_pop;
  logic [55:0] load_data;

  // wr_ready depends only on registered RAM occupancy, never on rd_ready.
  assign wr_ready = ~reset & (ram_cnt_q < 7'd64);
  assign rd_valid = ~reset & (out_cnt_q != 2'd0);
  assign rd_data  = buf0_q;

  assign push = wr_valid & wr_ready;
  assign pop  = rd_valid & rd_ready;

  // Output-stage entries left after this cycle's pop (pop implies out_cnt_q > 0).
  assign occ_after_pop = out_cnt_q - {1'b0, pop};

  // Fetch only if the skid buffer can absorb the word when it returns next cycle.
  assign read_issue = ~reset & (ram_cnt_q != 7'd0) &
                      (({1'b0, occ_after_pop} + {2'b00, inflight_q}) < 3'd2);

`ifdef ARAM_FIFO_BYPASS_EN
  // Only safe when nothing older sits in the RAM or is returning from it.
  assign bypass = push & (ram_cnt_q == 7'd0) & ~inflight_q & (occ_after_pop < 2'd2);
`else
  assign bypass = 1'b0;
`endif

  assign ram_wr    = push & ~bypass;
  assign ram_ena   = ram_wr;
  assign ram_wea   = ram_wr;
  assign ram_addra = wptr_q;
  assign ram_dia   = wr_data;
  assign ram_enb   = read_issue;
  assign ram_addrb = rptr_q;

  // A returning read and a bypass load are mutually exclusive (bypass needs inflight = 0).
  assign load      = inflight_q | bypass;
  assign load_data = inflight_q ? ram_dob : wr_data;

  assign count = reset ? 7'd0 : (ram_cnt_q + {6'd0, inflight_q} + {5'd0, out_cnt_q});
  assign almost_full = ~reset & (32'(count) >= AFULL_THRESH);

  always_comb begin
    ram_cnt_d = ram_cnt_q + {6'd0, ram_wr} - {6'd0, read_issue};
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (load) begin
      if (occ_after_pop == 2'd0) begin
        buf0_d = load_data;
      end else begin
        buf1_d = load_data;
      end
    end
    out_cnt_d = occ_after_pop + {1'b0, load};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= 6'd0;
      rptr_q     <= 6'd0;
      ram_cnt_q  <= 7'd0;
      inflight_q <= 1'b0;  // drops any read still returning from the RAM
      out_cnt_q  <= 2'd0;
    end else begin
      if (ram_wr) begin
        wptr_q <= wptr_q + 6'd1;
      end
      if (read_issue) begin
        rptr_q <= rptr_q + 6'd1;
      end
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= read_issue;
      out_cnt_q  <= out_cnt_d;
    end
  end

  // Data registers need no reset; out_cnt_q qualifies them.
  always_ff @(posedge clk) begin
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

endmodule

// File: tb/tb_aram_fifo_ctl_64x56.sv
module tb_aram_fifo_ctl_64x56;

`ifdef ARAM_FIFO_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        rd_ready = 1'b0;
  logic [55:0] wr_data = '0;
  logic        wr_ready, rd_valid, ram_ena, ram_wea, ram_enb, almost_full;
  logic [55:0] rd_data, ram_dia;
  logic [55:0] ram_dob = '0;
  logic [5:0]  ram_addra, ram_addrb;
  logic [6:0]  count;

  aram_fifo_ctl_64x56 #(.AFULL_THRESH(48)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, 1-cycle registered read.
  logic [55:0] mem [64];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  int total = 0;
  int bad = 0;
  logic [55:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  int          cyc = 0;
  int          occ = 0;
  int          pops = 0;
  int          first_pop = -1;
  int          last_pop = -1;
  int          wraps = 0;
  logic [5:0]  exp_wa = '0, exp_ra = '0;
  logic        prev_stall = 1'b0;
  logic [55:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      occ        = 0;
      exp_wa     = '0;
      exp_ra     = '0;
      prev_stall = 1'b0;
    end else begin
      chk("count_vs_occupancy", count, occ);
      if (prev_stall) begin
        chk("hold_valid", rd_valid, 1);
        chk("hold_data", rd_data, prev_data);
      end
      if (ram_ena) begin
        chk("ram_wr_addr", ram_addra, exp_wa);
        if (ram_addra == 6'd63) wraps++;
        exp_wa = exp_wa + 6'd1;
      end
      if (ram_enb) begin
        chk("ram_rd_addr", ram_addrb, exp_ra);
        exp_ra = exp_ra + 6'd1;
      end
      if (ram_ena && ram_enb) chk("rd_wr_addr_clash", ram_addra == ram_addrb, 0);
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_pop");
        else chk("rd_data", rd_data, exp_q.pop_front());
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      occ = occ + int'(wr_valid && wr_ready) - int'(rd_valid && rd_ready);
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
    end
  end

  // Call aligned #1 after a rising edge; returns #1 after the accepting edge.
  task automatic do_push(input logic [55:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    while (!wr_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!wr_ready) fail_now("push_timeout");
    else exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  logic pdone;
  int   pops0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_ram_ena", ram_ena, 0);
    chk("rst_ram_wea", ram_wea, 0);
    chk("rst_ram_enb", ram_enb, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_wr_ready", wr_ready, 1);
    chk("post_rst_count", count, 0);

    // Single word latency into an empty FIFO
    @(posedge clk); #1;
    do_push(56'hA5);
    wr_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("latency_rd_valid", rd_valid, (k >= LAT) ? 1 : 0);
    end
    chk("single_rd_data", rd_data, 56'hA5);
    chk("single_count", count, 1);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    wait_empty(20);
    @(posedge clk); #1;
    rd_ready = 1'b0;

    // Fill to 66 with no reads
    for (int k = 1; k <= 66; k++) begin
      do_push(56'h1000 + 56'(k));
      chk("fill_count", count, k);
      chk("fill_almost_full", almost_full, (k >= 48) ? 1 : 0);
    end
    wr_valid = 1'b0;
    chk("full_wr_ready", wr_ready, 0);
    wr_valid = 1'b1;
    wr_data  = 56'hDEAD;
    repeat (2) @(negedge clk);
    chk("full_wr_ready_held", wr_ready, 0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("full_count_held", count, 66);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    wait_empty(300);
    @(posedge clk); #1;

    // Streaming 200 words, read always ready
    wraps     = 0;
    first_pop = -1;
    pops0     = pops;
    for (int k = 0; k < 200; k++) do_push(56'h20000 + 56'(k));
    wr_valid = 1'b0;
    wait_empty(50);
    chk("stream_pops", pops - pops0, 200);
    chk("stream_no_bubbles", last_pop - first_pop, 199);
`ifndef ARAM_FIFO_BYPASS_EN
    chk("stream_wraps", wraps, 3);
`endif
    @(posedge clk); #1;
    rd_ready = 1'b0;

    // Random read stalls at low occupancy
    pdone = 1'b0;
    pops0 = pops;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          int n = 0;
          while (count >= 7'd2 && n < 100) begin
            n++;
            @(posedge clk); #1;
          end
          if (n >= 100) fail_now("occ_wait_timeout");
          do_push(56'h30000 + 56'(k));
          wr_valid = 1'b0;
        end
        pdone = 1'b1;
      end
      begin
        int n = 0;
        while (!(pdone && exp_q.size() == 0) && n < 800) begin
          @(posedge clk); #1;
          rd_ready = 1'($urandom_range(0, 1));
          n++;
        end
        if (n >= 800) fail_now("stall_phase_timeout");
        rd_ready = 1'b0;
      end
    join
    chk("stall_pops", pops - pops0, 30);

    // Reset while a read is in flight
    @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) do_push(56'h500 + 56'(k));
    wr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_reset_count", count, 5);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!(ram_enb && count == 7'd5) && n < 10) begin
        n++;
        @(negedge clk);
      end
      if (n >= 10) fail_now("read_issue_wait_timeout");
    end
    @(posedge clk); #1;
    rd_ready = 1'b0;
    reset    = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_count", count, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_wr_ready", wr_ready, 0);
    chk("midrst_ram_enb", ram_enb, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("after_rst_rd_valid", rd_valid, 0);
    chk("after_rst_count", count, 0);
    chk("after_rst_wr_ready", wr_ready, 1);
    @(posedge clk); #1;
    pops0 = pops;
    do_push(56'hBEEF);
    wr_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("after_rst_latency", rd_valid, (k >= LAT) ? 1 : 0);
    end
    chk("after_rst_data", rd_data, 56'hBEEF);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    wait_empty(20);
    @(posedge clk); #1;
    rd_ready = 1'b0;
    chk("after_rst_pops", pops - pops0, 1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
